// File: rtl/modq_reduce_pipe_pkg.sv
// modq_pkg: shared constants and helpers for the Kyber q=3329 reducer.
//   KYBER_Q / Q2     : modulus and twice the modulus
//   C_W / R_W        : input product width / residue width
//   CS_C_W / CS_S_W  : widths of the stage-1 carry/sum pair
//   q_neg(r)         : modular negation of a canonical residue (0 maps to 0)
package modq_pkg;

    localparam logic [11:0] KYBER_Q = 12'd3329;
    localparam logic [12:0] Q2      = 13'd6658;

    localparam int unsigned C_W    = 24;
    localparam int unsigned R_W    = 12;
    localparam int unsigned CS_C_W = 15;
    localparam int unsigned CS_S_W = 14;

    function automatic logic [R_W-1:0] q_neg(input logic [R_W-1:0] r);
        return (r == '0) ? '0 : (KYBER_Q - r);
    endfunction

endpackage

// File: rtl/modq_reduce_pipe_if.sv
// modq_reduce_pipe_if: valid/ready beat interface of the reducer.
//   in_valid/in_ready   : input handshake
//   in_c                : LANES x 24-bit products, lane i at [24*i +: 24]
//   in_neg / in_tag     : per-beat negate flag and sideband tag
//   out_valid/out_ready : output handshake
//   out_r / out_tag     : LANES x 12-bit residues, lane i at [12*i +: 12], and tag
// slave is the reducer's view, master is the producer/consumer view.
interface modq_reduce_pipe_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned TAG_W = 4
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [LANES*24-1:0]   in_c;
    logic                  in_neg;
    logic [TAG_W-1:0]      in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [LANES*12-1:0]   out_r;
    logic [TAG_W-1:0]      out_tag;

    modport slave (
        input  in_valid, in_c, in_neg, in_tag, out_ready,
        output in_ready, out_valid, out_r, out_tag
    );

    modport master (
        output in_valid, in_c, in_neg, in_tag, out_ready,
        input  in_ready, out_valid, out_r, out_tag
    );

endinterface

// File: rtl/modq_reduce_pipe_lane_core.sv
// modq_lane_core: combinational single-lane reduction mod 3329, split into two halves
// so the caller can place the stage-1 register between them.
//   c_i          : 24-bit unsigned product
//   c0_o / s0_o  : compressed pair, C0 (15b two's complement) and S0 (14b unsigned)
//   c0_i / s0_i  : registered pair fed back for correction
//   neg_i        : return (q - r) mod q instead of r
//   r_o          : canonical residue in [0, 3328]
module modq_lane_core
    import modq_pkg::*;
(
    input  logic [C_W-1:0]    c_i,
    output logic [CS_C_W-1:0] c0_o,
    output logic [CS_S_W-1:0] s0_o,
    input  logic [CS_C_W-1:0] c0_i,
    input  logic [CS_S_W-1:0] s0_i,
    input  logic              neg_i,
    output logic [R_W-1:0]    r_o
);

    // Repeated folds with 2^12 = 767 (mod q); each bound is the worst case of the previous one.
    logic [21:0] v1;  // <= 3144960
    logic [19:0] v2;  // <= 592384
    logic [16:0] v3;  // <= 114543
    logic [14:0] v4;  // <= 24804
    logic [14:0] a5;  // <= 6*767

    always_comb begin
        v1   = 22'(c_i[23:12]) * 22'd767 + 22'(c_i[11:0]);
        v2   = 20'(v1[21:12]) * 20'd767 + 20'(v1[11:0]);
        v3   = 17'(v2[19:12]) * 17'd767 + 17'(v2[11:0]);
        v4   = 15'(v3[16:12]) * 15'd767 + 15'(v3[11:0]);
        a5   = 15'(v4[14:12]) * 15'd767;
        // Offset by -q so C0 + S0 lands in [-q, 2q) and every correction branch is reachable.
        c0_o = a5 - 15'(KYBER_Q);
        s0_o = {2'b00, v4[11:0]};
    end

    logic [14:0] t, t_m1, t_m2, t_p1, r15;
    logic [2:0]  sel;
    logic [11:0] r_raw;
    logic        unused_r15;

    always_comb begin
        t     = c0_i + 15'(s0_i);
        t_m1  = t - 15'(KYBER_Q);
        t_m2  = t - 15'(Q2);
        t_p1  = t + 15'(KYBER_Q);
        sel   = {t_m2[14], t_m1[14], t[14]};
        r15   = '0;
        assert (sel inside {3'b000, 3'b100, 3'b110, 3'b111});
        unique case (sel)
            3'b000:  r15 = t_m2;
            3'b100:  r15 = t_m1;
            3'b110:  r15 = t;
            3'b111:  r15 = t_p1;
            default: r15 = '0;
        endcase
        r_raw = r15[11:0];
        r_o   = neg_i ? q_neg(r_raw) : r_raw;
    end

    // Upper bits of the selected value are zero by construction.
    assign unused_r15 = ^r15[14:12];

endmodule

// File: rtl/modq_reduce_pipe.sv
// modq_reduce_pipe: LANES-wide pipelined reducer of 24-bit products to residues mod 3329.
//   clk     : system clock, rising edge
//   rst_n   : synchronous reset, active low
//   bus_io  : beat interface (slave modport), see modq_reduce_pipe_if
// PIPE=1 drives out_r combinationally from the stage-1 registers; PIPE=2 adds a
// register stage on out_r/out_tag. All stages move together under one global stall.
module modq_reduce_pipe
    import modq_pkg::*;
#(
    parameter int unsigned LANES = 4,
    parameter int unsigned PIPE  = 2,
    parameter int unsigned TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    modq_reduce_pipe_if.slave  bus_io
);

    logic advance;
    logic out_valid;

    logic [LANES-1:0][CS_C_W-1:0] c0_d, c0_q;
    logic [LANES-1:0][CS_S_W-1:0] s0_d, s0_q;
    logic [LANES-1:0][R_W-1:0]    r_comb;
    logic                         v1_q, neg1_q;
    logic [TAG_W-1:0]             tag1_q;

    // Stalls only when a result is presented and not taken; no path from in_valid.
    assign advance        = bus_io.out_ready | ~out_valid;
    assign bus_io.in_ready = advance;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        modq_lane_core u_lane (
            .c_i   (bus_io.in_c[C_W*i +: C_W]),
            .c0_o  (c0_d[i]),
            .s0_o  (s0_d[i]),
            .c0_i  (c0_q[i]),
            .s0_i  (s0_q[i]),
            .neg_i (neg1_q),
            .r_o   (r_comb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            c0_q   <= '0;
            s0_q   <= '0;
            neg1_q <= 1'b0;
            tag1_q <= '0;
        end else if (advance) begin
            v1_q   <= bus_io.in_valid;
            c0_q   <= c0_d;
            s0_q   <= s0_d;
            neg1_q <= bus_io.in_neg;
            tag1_q <= bus_io.in_tag;
        end
    end

    if (PIPE == 2) begin : g_pipe2
        logic                      v2_q;
        logic [LANES-1:0][R_W-1:0] r2_q;
        logic [TAG_W-1:0]          tag2_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2_q   <= 1'b0;
                r2_q   <= '0;
                tag2_q <= '0;
            end else if (advance) begin
                v2_q   <= v1_q;
                r2_q   <= r_comb;
                tag2_q <= tag1_q;
            end
        end

        assign out_valid      = v2_q;
        assign bus_io.out_r   = r2_q;
        assign bus_io.out_tag = tag2_q;
    end else begin : g_pipe1
        assign out_valid      = v1_q;
        assign bus_io.out_r   = r_comb;
        assign bus_io.out_tag = tag1_q;
    end

    assign bus_io.out_valid = out_valid;

endmodule
